// File: rtl/tty_ctl.sv
// tty_ctl: KL8E-style console controller placed between the PDP-8 IOT bus and
// an asynchronous uart.
//
// Keyboard (KBD_DEV) and printer (TTY_DEV) IOTs are decoded combinationally.
// The keyboard flag, printer flag and interrupt enable are held here. The
// uart's four-phase req/ack load/unload handshakes are sequenced here, and the
// uart's baud clock enables are generated here.
//
// State table
//   TX state | meaning
//   IDLE     | no character in flight, a print may be accepted
//   REQ      | uart_tx_req high, waiting for uart_tx_ack
//   REL      | request dropped, waiting for uart_tx_ack to fall
//   START    | waiting for the uart transmitter to go busy
//   BUSY     | waiting for the uart transmitter to go idle again
//   DONE     | character sent, sets the printer flag
//
//   RX state | meaning
//   IDLE     | waiting for a character while the keyboard flag is clear
//   REQ      | uart_rx_req high, waiting for uart_rx_ack
//   REL      | request dropped, latches data when uart_rx_ack falls
//
// Ports
//   clk, reset           system clock, synchronous active-high reset
//   iot, io_dev, io_op   one-cycle IOT strobe with device code and op bits
//   io_data_in           AC[4:11] from the CPU
//   io_data_out/_rd      data ORed into AC, and its valid strobe
//   io_skip, io_clear_ac skip and clear-AC requests (valid only while iot=1)
//   interrupt            registered interrupt request level
//   rx_tick, tx_tick     uart rx (16x baud) and tx (1x baud) clock enables
//   uart_tx_*            uart load handshake, character and idle status
//   uart_rx_*            uart unload handshake, character and empty status
//   tx_overrun           sticky: a print arrived while a character was in flight
module tty_ctl #(
  parameter int         CLK_DIV = 16,
  parameter logic [5:0] KBD_DEV = 6'o03,
  parameter logic [5:0] TTY_DEV = 6'o04
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iot,
  input  logic [5:0] io_dev,
  input  logic [2:0] io_op,
  input  logic [7:0] io_data_in,
  output logic [7:0] io_data_out,
  output logic       io_data_rd,
  output logic       io_skip,
  output logic       io_clear_ac,
  output logic       interrupt,
  output logic       rx_tick,
  output logic       tx_tick,
  output logic       uart_tx_req,
  input  logic       uart_tx_ack,
  output logic [7:0] uart_tx_data,
  input  logic       uart_tx_empty,
  output logic       uart_rx_req,
  input  logic       uart_rx_ack,
  input  logic [7:0] uart_rx_data,
  input  logic       uart_rx_empty,
  output logic       tx_overrun
);

  localparam int               DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    TX_IDLE, TX_REQ, TX_REL, TX_START, TX_BUSY, TX_DONE
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE, RX_REQ, RX_REL
  } rx_state_t;

  tx_state_t        tx_state;
  rx_state_t        rx_state;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       tick_cnt;
  logic             kbd_flag;
  logic             tty_flag;
  logic             ie;
  logic [7:0]       kbd_buf;
  logic [7:0]       tx_buf;

  // decoded IOT side effects, applied at the next clock edge
  logic kbd_clr;
  logic tty_clr;
  logic tty_set_iot;
  logic ie_wr;
  logic print;

  // hardware flag sets; these override an IOT clear in the same cycle
  logic tty_set_hw;
  logic kbd_set_hw;

  assign rx_tick      = (div_cnt == DIV_LAST);
  assign tx_tick      = rx_tick && (tick_cnt == 4'hF);
  assign uart_tx_data = tx_buf;

  assign tty_set_hw = (tx_state == TX_DONE);
  assign kbd_set_hw = (rx_state == RX_REL) && !uart_rx_ack;

  always_comb begin
    io_skip     = 1'b0;
    io_clear_ac = 1'b0;
    io_data_rd  = 1'b0;
    kbd_clr     = 1'b0;
    tty_clr     = 1'b0;
    tty_set_iot = 1'b0;
    ie_wr       = 1'b0;
    print       = 1'b0;
    if (iot && (io_dev == KBD_DEV)) begin
      case (io_op)
        3'd0: kbd_clr = 1'b1;
        3'd1: io_skip = kbd_flag;
        3'd2: begin
          io_clear_ac = 1'b1;
          kbd_clr     = 1'b1;
        end
        3'd4: io_data_rd = 1'b1;
        3'd5: ie_wr = 1'b1;
        3'd6: begin
          io_clear_ac = 1'b1;
          io_data_rd  = 1'b1;
          kbd_clr     = 1'b1;
        end
        default: ;
      endcase
    end else if (iot && (io_dev == TTY_DEV)) begin
      case (io_op)
        3'd0: tty_set_iot = 1'b1;
        3'd1: io_skip = tty_flag;
        3'd2: tty_clr = 1'b1;
        3'd4: print = 1'b1;
        3'd5: io_skip = kbd_flag | tty_flag;
        3'd6: begin
          tty_clr = 1'b1;
          print   = 1'b1;
        end
        default: ;
      endcase
    end
    io_data_out = io_data_rd ? kbd_buf : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state    <= TX_IDLE;
      rx_state    <= RX_IDLE;
      div_cnt     <= '0;
      tick_cnt    <= 4'h0;
      kbd_flag    <= 1'b0;
      tty_flag    <= 1'b0;
      ie          <= 1'b1;
      kbd_buf     <= 8'h00;
      tx_buf      <= 8'h00;
      tx_overrun  <= 1'b0;
      interrupt   <= 1'b0;
      uart_tx_req <= 1'b0;
      uart_rx_req <= 1'b0;
    end else begin
      if (rx_tick) begin
        div_cnt  <= '0;
        tick_cnt <= tick_cnt + 4'h1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      if (ie_wr) ie <= io_data_in[0];

      // uses the pre-edge flags and enable, giving the one-clock lag
      interrupt <= ie & (kbd_flag | tty_flag);

      case (tx_state)
        TX_IDLE: begin
          if (print) begin
            tx_buf      <= io_data_in;
            uart_tx_req <= 1'b1;
            tx_state    <= TX_REQ;
          end
        end
        TX_REQ: begin
          if (uart_tx_ack) begin
            uart_tx_req <= 1'b0;
            tx_state    <= TX_REL;
          end
        end
        TX_REL:   if (!uart_tx_ack)  tx_state <= TX_START;
        TX_START: if (!uart_tx_empty) tx_state <= TX_BUSY;
        TX_BUSY:  if (uart_tx_empty)  tx_state <= TX_DONE;
        TX_DONE:  tx_state <= TX_IDLE;
        default:  tx_state <= TX_IDLE;
      endcase

      if (print && (tx_state != TX_IDLE)) tx_overrun <= 1'b1;

      case (rx_state)
        RX_IDLE: begin
          // a held keyboard flag leaves the next character in the uart
          if (!uart_rx_empty && !kbd_flag) begin
            uart_rx_req <= 1'b1;
            rx_state    <= RX_REQ;
          end
        end
        RX_REQ: begin
          if (uart_rx_ack) begin
            uart_rx_req <= 1'b0;
            rx_state    <= RX_REL;
          end
        end
        RX_REL: begin
          if (!uart_rx_ack) begin
            kbd_buf  <= uart_rx_data;
            rx_state <= RX_IDLE;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase

      if (kbd_set_hw)   kbd_flag <= 1'b1;
      else if (kbd_clr) kbd_flag <= 1'b0;

      if (tty_set_hw || tty_set_iot) tty_flag <= 1'b1;
      else if (tty_clr)              tty_flag <= 1'b0;
    end
  end

endmodule
